// File: rtl/mat_mul_pkg.sv
// Shared defaults, FSM encoding and element addressing for the sequential
// N x N matrix multiplier. Build option: MAT_MUL_SIGNED_EN (see mac_step).
package mat_mul_pkg;

   localparam int N_DEF      = 3;
   localparam int DATA_W_DEF = 8;
   localparam int ACC_W_DEF  = 18;
   localparam int IDX_W_DEF  = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      OUT  = 2'd2
   } state_t;

   // Bit offset of element (row, col) inside a row-major packed matrix whose
   // element [0][0] sits in the most significant w bits. Shifting the packed
   // matrix right by this amount leaves the element in the low w bits.
   function automatic int elem_shift(input int row, input int col,
                                     input int n, input int w);
      return (n * n - 1 - (row * n + col)) * w;
   endfunction

endpackage

// File: rtl/mat_mul_seq_mac_step.sv
// One multiply-accumulate step: acc_o = acc_i + a_i * b_i, ACC_W wide.
// Build option MAT_MUL_SIGNED_EN: operands are two's complement and are
// sign-extended; otherwise they are zero-extended. The low ACC_W bits of the
// product are the same for both interpretations once extended, so only the
// extension differs.
module mac_step #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 18
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [ACC_W-1:0]  acc_i,
   output logic [ACC_W-1:0]  acc_o
);

   logic [ACC_W-1:0] a_x;
   logic [ACC_W-1:0] b_x;

`ifdef MAT_MUL_SIGNED_EN
   assign a_x = {{(ACC_W-DATA_W){a_i[DATA_W-1]}}, a_i};
   assign b_x = {{(ACC_W-DATA_W){b_i[DATA_W-1]}}, b_i};
`else
   assign a_x = {{(ACC_W-DATA_W){1'b0}}, a_i};
   assign b_x = {{(ACC_W-DATA_W){1'b0}}, b_i};
`endif

   assign acc_o = acc_i + a_x * b_x;

endmodule

// File: rtl/mat_mul_seq.sv
// Sequential N x N matrix multiply C = A*B sharing a single MAC step.
// Latches A/B on accept, spends N cycles per C element, then presents each
// element (row-major, tagged with row/col) until the consumer takes it.
// Build option MAT_MUL_SIGNED_EN selects two's-complement operands.
module mat_mul_seq
   import mat_mul_pkg::*;
#(
   parameter int N      = N_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int IDX_W  = IDX_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N*N*DATA_W-1:0] a_mat,
   input  logic [N*N*DATA_W-1:0] b_mat,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_W-1:0]      out_data,
   output logic [IDX_W-1:0]      out_row,
   output logic [IDX_W-1:0]      out_col,
   output logic                  out_last,
   output logic                  busy
);

   localparam int               MAT_W    = N * N * DATA_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   state_t             state_q, state_d;
   logic [MAT_W-1:0]   a_q, a_d, b_q, b_d;
   logic [IDX_W-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
   logic [ACC_W-1:0]   acc_q, acc_d, mac_sum;
   logic [ACC_W-1:0]   data_q, data_d;
   logic [IDX_W-1:0]   row_q, row_d, col_q, col_d;
   logic               last_q, last_d, valid_q, valid_d;
   logic [DATA_W-1:0]  a_el, b_el;

   // Current product operands: A[i][k] and B[k][j] from the latched matrices.
   assign a_el = DATA_W'(a_q >> elem_shift(int'(i_q), int'(k_q), N, DATA_W));
   assign b_el = DATA_W'(b_q >> elem_shift(int'(k_q), int'(j_q), N, DATA_W));

   mac_step #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .a_i   (a_el),
      .b_i   (b_el),
      .acc_i (acc_q),
      .acc_o (mac_sum)
   );

   // Forced low during reset so nothing is accepted before the block is clean.
   assign in_ready  = (state_q == IDLE) && !rst;
   assign busy      = (state_q != IDLE);
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_row   = row_q;
   assign out_col   = col_q;
   assign out_last  = last_q;

   // Next-state and datapath updates for accept / accumulate / present.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      i_d     = i_q;
      j_d     = j_q;
      k_d     = k_q;
      acc_d   = acc_q;
      data_d  = data_q;
      row_d   = row_q;
      col_d   = col_q;
      last_d  = last_q;
      valid_d = valid_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               a_d     = a_mat;
               b_d     = b_mat;
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
               acc_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            if (k_q == LAST_IDX) begin
               // Final product goes straight to the output register.
               data_d  = mac_sum;
               row_d   = i_q;
               col_d   = j_q;
               last_d  = (i_q == LAST_IDX) && (j_q == LAST_IDX);
               valid_d = 1'b1;
               state_d = OUT;
            end else begin
               acc_d = mac_sum;
               k_d   = k_q + 1'b1;
            end
         end
         OUT: begin
            if (out_ready) begin
               valid_d = 1'b0;
               if (last_q) begin
                  state_d = IDLE;
               end else begin
                  if (j_q == LAST_IDX) begin
                     j_d = '0;
                     i_d = i_q + 1'b1;
                  end else begin
                     j_d = j_q + 1'b1;
                  end
                  k_d     = '0;
                  acc_d   = '0;
                  state_d = CALC;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any job in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         acc_q   <= '0;
         data_q  <= '0;
         row_q   <= '0;
         col_q   <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         data_q  <= data_d;
         row_q   <= row_d;
         col_q   <= col_d;
         last_q  <= last_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: tb/tb_mat_mul_seq.sv
// Self-checking bench for mat_mul_seq (N=3, DATA_W=8, ACC_W=18).
// Honours MAT_MUL_SIGNED_EN in its reference model.
module tb_mat_mul_seq;

   localparam int N     = 3;
   localparam int DW    = 8;
   localparam int AW    = 18;
   localparam int IW    = 2;
   localparam int MW    = N * N * DW;

   typedef logic [N*N-1:0][AW-1:0] cvec_t;

   typedef struct {
      logic [MW-1:0] a;
      logic [MW-1:0] b;
      cvec_t         exp;
      int            stall_e;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, out_valid, out_ready, out_last, busy;
   logic [MW-1:0] a_mat, b_mat;
   logic [AW-1:0] out_data;
   logic [IW-1:0] out_row, out_col;

   int n_tests = 0;
   int n_fail  = 0;

   mat_mul_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_mat     (a_mat),
      .b_mat     (b_mat),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_row   (out_row),
      .out_col   (out_col),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [MW-1:0] rnd_mat();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[MW-1:0];
   endfunction

   // Element (r,c) of a row-major packed matrix, [0][0] in the top byte.
   function automatic int elem(input logic [MW-1:0] m, input int r, input int c);
      logic [DW-1:0] v;
      v = m[(N*N-1-(r*N+c))*DW +: DW];
`ifdef MAT_MUL_SIGNED_EN
      return int'($signed(v));
`else
      return int'(v);
`endif
   endfunction

   // Reference: textbook triple loop in integer arithmetic, truncated to ACC_W.
   function automatic cvec_t model(input logic [MW-1:0] a, input logic [MW-1:0] b);
      cvec_t c;
      for (int r = 0; r < N; r++)
         for (int q = 0; q < N; q++) begin
            int s;
            s = 0;
            for (int k = 0; k < N; k++) s += elem(a, r, k) * elem(b, k, q);
            c[r*N+q] = AW'(s);
         end
      return c;
   endfunction

   // Runs one job. stall_e: element held with out_ready=0 for stall_n cycles.
   // hold: keep in_valid high with (na,nb) during the job. abort_e: reset
   // asserted during the computation of that element.
   task automatic run_job(input logic [MW-1:0] a, input logic [MW-1:0] b, input cvec_t exp,
                          input int stall_e, input int stall_n, input bit hold,
                          input logic [MW-1:0] na, input logic [MW-1:0] nb, input int abort_e);
      int cnt;
      bit seen;
      in_valid = 1'b1;
      a_mat    = a;
      b_mat    = b;
      cnt      = 0;
      while (!in_ready && cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk("accept_ready", 32'(in_ready), 32'd1);
      if (!in_ready) return;
      @(posedge clk); #1;
      chk("busy_after_accept", 32'(busy), 32'd1);
      if (hold) begin
         a_mat = na;
         b_mat = nb;
      end else begin
         in_valid = 1'b0;
         a_mat    = rnd_mat();
         b_mat    = rnd_mat();
      end
      for (int e = 0; e < N*N; e++) begin
         if (e == abort_e) begin
            @(posedge clk); #1;
            rst = 1'b1;
            #1;
            chk("abort_outs", 32'({out_valid, out_data, out_row, out_col, out_last, busy, in_ready}), 32'd0);
            @(posedge clk); #1;
            chk("abort_held", 32'({out_valid, out_data, busy, in_ready}), 32'd0);
            rst      = 1'b0;
            in_valid = 1'b0;
            #1;
            chk("abort_in_ready", 32'(in_ready), 32'd1);
            seen = 1'b0;
            repeat (6) begin
               out_ready = 1'($urandom_range(0, 1));
               @(posedge clk); #1;
               if (out_valid || busy) seen = 1'b1;
            end
            chk("abort_no_output", 32'(seen), 32'd0);
            out_ready = 1'b0;
            return;
         end
         cnt = 0;
         do begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cnt++;
         end while (!out_valid && cnt < 20);
         out_ready = 1'b0;
         chk("latency", 32'(cnt), 32'(N));
         chk("out_data", 32'(out_data), 32'(exp[e]));
         chk("out_row_col", 32'({out_row, out_col}), 32'({IW'(e / N), IW'(e % N)}));
         chk("out_last", 32'(out_last), 32'(e == N*N-1));
         if (!out_valid) return;
         if (e == stall_e) begin
            repeat (stall_n) begin
               @(posedge clk); #1;
               chk("stall_hold", 32'({out_valid, out_data, out_row, out_col, out_last}),
                   32'({1'b1, exp[e], IW'(e / N), IW'(e % N), 1'(e == N*N-1)}));
               chk("stall_in_ready", 32'(in_ready), 32'd0);
            end
         end
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
      end
      chk("job_done", 32'({in_ready, out_valid, busy}), 32'b100);
   endtask

   vec_t vt[4];

   initial begin
      cvec_t          c;
      logic [MW-1:0]  ident, a2, b2;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a_mat     = '0;
      b_mat     = '0;
      ident     = {8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};

      // Directed vectors with hand-derived results.
      vt[0].a = ident;
      vt[0].b = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
      for (int e = 0; e < N*N; e++) vt[0].exp[e] = AW'(e + 1);
      vt[0].stall_e = -1;
      vt[1].a = {N*N{8'hFF}};
      vt[1].b = {N*N{8'hFF}};
`ifdef MAT_MUL_SIGNED_EN
      for (int e = 0; e < N*N; e++) vt[1].exp[e] = 18'd3;
`else
      for (int e = 0; e < N*N; e++) vt[1].exp[e] = 18'h2FA03;
`endif
      vt[1].stall_e = 3;
      vt[2].a = ident;
      vt[2].b = {8'd2, 8'd0, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0, 8'd2};
      for (int e = 0; e < N*N; e++) vt[2].exp[e] = (e % 4 == 0) ? 18'd2 : 18'd0;
      vt[2].stall_e = 8;
      vt[3].a = {N*N{8'hFF}};
      vt[3].b = ident;
`ifdef MAT_MUL_SIGNED_EN
      for (int e = 0; e < N*N; e++) vt[3].exp[e] = 18'h3FFFF;
`else
      for (int e = 0; e < N*N; e++) vt[3].exp[e] = 18'h000FF;
`endif
      vt[3].stall_e = -1;

      repeat (2) @(posedge clk);
      #1;
      chk("reset_outs", 32'({out_valid, out_data, out_row, out_col, out_last, busy, in_ready}), 32'd0);
      rst = 1'b0;
      #1;
      chk("reset_release_ready", 32'(in_ready), 32'd1);

      for (int v = 0; v < 4; v++)
         run_job(vt[v].a, vt[v].b, vt[v].exp, vt[v].stall_e, 5, 1'b0, '0, '0, -1);

      // Reset while C[1][1] is being accumulated, then a clean job.
      a2 = rnd_mat();
      b2 = rnd_mat();
      run_job(a2, b2, model(a2, b2), -1, 0, 1'b0, '0, '0, 4);
      run_job(vt[2].a, vt[2].b, vt[2].exp, -1, 0, 1'b0, '0, '0, -1);

      // Back-to-back: second job offered throughout the first one.
      a2 = rnd_mat();
      b2 = rnd_mat();
      run_job(vt[0].a, vt[0].b, vt[0].exp, -1, 0, 1'b1, a2, b2, -1);
      run_job(a2, b2, model(a2, b2), 4, 2, 1'b0, '0, '0, -1);

      // Random operands against the reference model.
      for (int t = 0; t < 6; t++) begin
         a2 = rnd_mat();
         b2 = rnd_mat();
         c  = model(a2, b2);
         run_job(a2, b2, c, int'($urandom_range(0, 8)), int'($urandom_range(1, 4)),
                 1'b0, '0, '0, -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
